// File: rtl/duckhunt_pkg.sv
// Shared constants and FSM state for the duck hit scheduler.
// Score logic is built only when DUCKHIT_SCORE_EN is defined.
package duckhunt_pkg;
  localparam int DEF_N_DUCKS   = 4;
  localparam int DEF_N_BULLETS = 8;
  localparam int DEF_DUCK_W    = 32;
  localparam int DEF_DUCK_H    = 32;
  localparam int DEF_SCORE_W   = 8;

  localparam int DUCK_X_W = 11;
  localparam int POS_W    = 10;
  localparam int CMP_W    = 12;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    REPORT
  } state_t;
endpackage

// File: rtl/hit_box_compare.sv
// Shared bounding-box window test for one duck/bullet pair.
// Inclusive-exclusive bounds on both axes, 12-bit signed deltas.
module hit_box_compare
  import duckhunt_pkg::*;
(
  input  logic [DUCK_X_W-1:0] duck_x,
  input  logic [POS_W-1:0]    duck_y,
  input  logic [POS_W-1:0]    bullet_x,
  input  logic [POS_W-1:0]    bullet_y,
  input  logic [CMP_W-1:0]    box_w,
  input  logic [CMP_W-1:0]    box_h,
  output logic                hit
);
  logic [CMP_W-1:0] dx;
  logic [CMP_W-1:0] dy;

  // Sign bit set means the bullet lies left of / above the box.
  assign dx = {2'b00, bullet_x} - {duck_x[DUCK_X_W-1], duck_x};
  assign dy = {2'b00, bullet_y} - {2'b00, duck_y};

  assign hit = !dx[CMP_W-1] && (dx < box_w) &&
               !dy[CMP_W-1] && (dy < box_h);
endmodule

// File: rtl/duck_hit_scheduler.sv
// Serial duck/bullet collision scan, one pair per cycle per frame.
// Define DUCKHIT_SCORE_EN to build the saturating score counter.
module duck_hit_scheduler
  import duckhunt_pkg::*;
#(
  parameter int N_DUCKS   = DEF_N_DUCKS,
  parameter int N_BULLETS = DEF_N_BULLETS,
  parameter int DUCK_W    = DEF_DUCK_W,
  parameter int DUCK_H    = DEF_DUCK_H,
  parameter int SCORE_W   = DEF_SCORE_W
) (
  input  logic                          vga_clk,
  input  logic                          reset_n,
  input  logic                          frame_tick,
  input  logic [DUCK_X_W*N_DUCKS-1:0]   duck_x,
  input  logic [POS_W*N_DUCKS-1:0]      duck_y,
  input  logic [N_DUCKS-1:0]            duck_alive,
  input  logic [POS_W*N_BULLETS-1:0]    bullet_x,
  input  logic [POS_W*N_BULLETS-1:0]    bullet_y,
  input  logic [N_BULLETS-1:0]          bullet_valid,
  output logic [N_DUCKS-1:0]            duck_hit,
  output logic [N_BULLETS-1:0]          bullet_kill,
  output logic [SCORE_W-1:0]            score,
  output logic                          busy,
  output logic                          overrun
);
  localparam int DW = (N_DUCKS > 1) ? $clog2(N_DUCKS) : 1;
  localparam int BW = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(N_DUCKS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(N_BULLETS - 1);

  state_t state;
  state_t state_n;

  logic [DW-1:0]       d_idx;
  logic [BW-1:0]       b_idx;
  logic [DUCK_X_W-1:0] sx  [N_DUCKS];
  logic [POS_W-1:0]    sy  [N_DUCKS];
  logic [POS_W-1:0]    sbx [N_BULLETS];
  logic [POS_W-1:0]    sby [N_BULLETS];
  logic [N_DUCKS-1:0]   salive;
  logic [N_DUCKS-1:0]   hitacc;
  logic [N_BULLETS-1:0] svalid;
  logic [N_BULLETS-1:0] killacc;
  logic box_hit;
  logic take;
  logic last_pair;
  logic start;
  logic ovr;

  hit_box_compare u_cmp (
    .duck_x   (sx[d_idx]),
    .duck_y   (sy[d_idx]),
    .bullet_x (sbx[b_idx]),
    .bullet_y (sby[b_idx]),
    .box_w    (CMP_W'(DUCK_W)),
    .box_h    (CMP_W'(DUCK_H)),
    .hit      (box_hit)
  );

  assign start     = (state == IDLE) && frame_tick;
  assign last_pair = (d_idx == D_LAST) && (b_idx == B_LAST);
  // Already-credited ducks and retired bullets drop out of the scan.
  assign take = (state == SCAN) && box_hit &&
                salive[d_idx] && svalid[b_idx] &&
                !hitacc[d_idx] && !killacc[b_idx];

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (frame_tick) state_n = SCAN;
      SCAN:    if (last_pair) state_n = REPORT;
      REPORT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      salive <= '0;
      svalid <= '0;
      for (int d = 0; d < N_DUCKS; d++) begin
        sx[d] <= '0;
        sy[d] <= '0;
      end
      for (int b = 0; b < N_BULLETS; b++) begin
        sbx[b] <= '0;
        sby[b] <= '0;
      end
    end else if (start) begin
      salive <= duck_alive;
      svalid <= bullet_valid;
      for (int d = 0; d < N_DUCKS; d++) begin
        sx[d] <= duck_x[DUCK_X_W*d +: DUCK_X_W];
        sy[d] <= duck_y[POS_W*d +: POS_W];
      end
      for (int b = 0; b < N_BULLETS; b++) begin
        sbx[b] <= bullet_x[POS_W*b +: POS_W];
        sby[b] <= bullet_y[POS_W*b +: POS_W];
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      d_idx   <= '0;
      b_idx   <= '0;
      hitacc  <= '0;
      killacc <= '0;
      ovr     <= 1'b0;
    end else begin
      if (frame_tick && state != IDLE) ovr <= 1'b1;
      if (start) begin
        d_idx   <= '0;
        b_idx   <= '0;
        hitacc  <= '0;
        killacc <= '0;
      end else if (state == SCAN) begin
        if (take) begin
          hitacc[d_idx]  <= 1'b1;
          killacc[b_idx] <= 1'b1;
        end
        if (b_idx == B_LAST) begin
          b_idx <= '0;
          d_idx <= (d_idx == D_LAST) ? '0 : d_idx + 1'b1;
        end else begin
          b_idx <= b_idx + 1'b1;
        end
      end
    end
  end

  assign duck_hit    = (state == REPORT) ? hitacc : '0;
  assign bullet_kill = (state == REPORT) ? killacc : '0;
  assign busy        = (state != IDLE);
  assign overrun     = ovr;

`ifdef DUCKHIT_SCORE_EN
  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W:0]   sum;

  always_comb begin
    sum = {1'b0, score_q};
    for (int d = 0; d < N_DUCKS; d++)
      sum = sum + {{SCORE_W{1'b0}}, hitacc[d]};
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n)
      score_q <= '0;
    else if (state == REPORT)
      score_q <= sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
  end

  assign score = score_q;
`else
  assign score = '0;
`endif
endmodule

// File: tb/tb_duck_hit_scheduler.sv
// Self-checking bench for duck_hit_scheduler with a pair-scan model.
// Score expectations follow DUCKHIT_SCORE_EN.
module tb_duck_hit_scheduler;
  localparam int ND = 4;
  localparam int NB = 8;
  localparam int BOX_W = 32;
  localparam int BOX_H = 32;
  localparam int SW = 8;
  localparam int SMAX = (1 << SW) - 1;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           frame_tick = 1'b0;
  logic [11*ND-1:0] duck_x = '0;
  logic [10*ND-1:0] duck_y = '0;
  logic [ND-1:0]    duck_alive = '0;
  logic [10*NB-1:0] bullet_x = '0;
  logic [10*NB-1:0] bullet_y = '0;
  logic [NB-1:0]    bullet_valid = '0;
  logic [ND-1:0]    duck_hit;
  logic [NB-1:0]    bullet_kill;
  logic [SW-1:0]    score;
  logic             busy;
  logic             overrun;

  int checks = 0;
  int failures = 0;

  int m_dx [ND];
  int m_dy [ND];
  bit m_alive [ND];
  int m_bx [NB];
  int m_by [NB];
  bit m_valid [NB];
  int sc_m = 0;
  bit ovr_m = 1'b0;

  duck_hit_scheduler #(
    .N_DUCKS(ND), .N_BULLETS(NB), .DUCK_W(BOX_W),
    .DUCK_H(BOX_H), .SCORE_W(SW)
  ) dut (
    .vga_clk(clk), .reset_n(reset_n),
    .frame_tick(frame_tick),
    .duck_x(duck_x), .duck_y(duck_y),
    .duck_alive(duck_alive),
    .bullet_x(bullet_x), .bullet_y(bullet_y),
    .bullet_valid(bullet_valid),
    .duck_hit(duck_hit), .bullet_kill(bullet_kill),
    .score(score), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < ND; d++) begin
      m_dx[d] = 0; m_dy[d] = 0; m_alive[d] = 0;
    end
    for (int b = 0; b < NB; b++) begin
      m_bx[b] = 0; m_by[b] = 0; m_valid[b] = 0;
    end
  endtask

  task automatic drive();
    logic [31:0] v;
    for (int d = 0; d < ND; d++) begin
      v = m_dx[d];
      duck_x[11*d +: 11] = v[10:0];
      v = m_dy[d];
      duck_y[10*d +: 10] = v[9:0];
      duck_alive[d] = m_alive[d];
    end
    for (int b = 0; b < NB; b++) begin
      v = m_bx[b];
      bullet_x[10*b +: 10] = v[9:0];
      v = m_by[b];
      bullet_y[10*b +: 10] = v[9:0];
      bullet_valid[b] = m_valid[b];
    end
  endtask

  // Duck-major scan: a duck takes its first free bullet in its box.
  task automatic model(output logic [ND-1:0] eh,
                       output logic [NB-1:0] ek);
    int ddx, ddy;
    eh = '0;
    ek = '0;
    for (int d = 0; d < ND; d++)
      for (int b = 0; b < NB; b++) begin
        ddx = m_bx[b] - m_dx[d];
        ddy = m_by[b] - m_dy[d];
        if (m_alive[d] && m_valid[b] && !eh[d] && !ek[b] &&
            ddx >= 0 && ddx < BOX_W && ddy >= 0 && ddy < BOX_H) begin
          eh[d] = 1'b1;
          ek[b] = 1'b1;
        end
      end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic randomize_model();
    int rd;
    for (int d = 0; d < ND; d++) begin
      m_dx[d] = int'($urandom_range(0, 800)) - 60;
      m_dy[d] = int'($urandom_range(0, 700));
      m_alive[d] = ($urandom_range(0, 3) != 0);
    end
    for (int b = 0; b < NB; b++) begin
      rd = int'($urandom_range(0, ND - 1));
      m_bx[b] = clampi(m_dx[rd] + int'($urandom_range(0, 44)) - 6, 0, 1023);
      m_by[b] = clampi(m_dy[rd] + int'($urandom_range(0, 44)) - 6, 0, 1023);
      m_valid[b] = ($urandom_range(0, 3) != 0);
    end
  endtask

  // Start at a negedge in IDLE. mode 1: extra tick mid-scan,
  // mode 2: extra tick during the report cycle.
  task automatic do_frame(input string tag, input int mode,
                          input bit scramble);
    logic [ND-1:0] eh;
    logic [NB-1:0] ek;
    int old_sc;
    model(eh, ek);
    old_sc = sc_m;
    drive();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk({tag, "_busy_start"}, busy, 1);
    if (scramble) begin
      randomize_model();
      drive();
    end
    for (int c = 2; c <= 32; c++) begin
      if (mode == 1 && c == 10) frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
    chk({tag, "_early_hit"}, duck_hit, 0);
    chk({tag, "_busy_scan"}, busy, 1);
    @(negedge clk);
    chk({tag, "_duck_hit"}, duck_hit, eh);
    chk({tag, "_bullet_kill"}, bullet_kill, ek);
    chk({tag, "_busy_rep"}, busy, 1);
    chk({tag, "_score_rep"}, score, old_sc);
    if (mode == 2) frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
`ifdef DUCKHIT_SCORE_EN
    sc_m = old_sc + $countones(eh);
    if (sc_m > SMAX) sc_m = SMAX;
`else
    sc_m = 0;
`endif
    if (mode != 0) ovr_m = 1'b1;
    chk({tag, "_hit_after"}, duck_hit, 0);
    chk({tag, "_kill_after"}, bullet_kill, 0);
    chk({tag, "_busy_idle"}, busy, 0);
    chk({tag, "_score"}, score, sc_m);
    chk({tag, "_overrun"}, overrun, ovr_m);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    sc_m = 0;
    ovr_m = 1'b0;
    chk("rst_hit", duck_hit, 0);
    chk("rst_kill", bullet_kill, 0);
    chk("rst_score", score, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    clear_model();
    drive();
    apply_reset();

    m_dx[0] = 100; m_dy[0] = 50; m_alive[0] = 1;
    m_bx[3] = 110; m_by[3] = 60; m_valid[3] = 1;
    do_frame("tp_basic", 0, 0);

    clear_model();
    m_dx[0] = 100; m_dy[0] = 50; m_alive[0] = 1;
    m_bx[0] = 132; m_by[0] = 50; m_valid[0] = 1;
    do_frame("tp_right_edge", 0, 0);
    m_bx[0] = 131; m_by[0] = 81;
    do_frame("tp_far_corner", 0, 0);
    m_bx[0] = 131; m_by[0] = 82;
    do_frame("tp_bottom_edge", 0, 0);
    m_bx[0] = 100; m_by[0] = 50;
    do_frame("tp_left_edge", 0, 0);
    m_bx[0] = 99;
    do_frame("tp_left_out", 0, 0);

    clear_model();
    m_dx[0] = -20; m_dy[0] = 200; m_alive[0] = 1;
    m_bx[5] = 5; m_by[5] = 210; m_valid[5] = 1;
    do_frame("tp_neg_x", 0, 0);
    m_alive[0] = 0;
    do_frame("tp_dead", 0, 0);

    clear_model();
    m_dx[0] = 300; m_dy[0] = 300; m_alive[0] = 1;
    m_dx[1] = 310; m_dy[1] = 310; m_alive[1] = 1;
    m_bx[6] = 320; m_by[6] = 320; m_valid[6] = 1;
    m_dx[2] = 600; m_dy[2] = 100; m_alive[2] = 1;
    m_bx[2] = 605; m_by[2] = 105; m_valid[2] = 1;
    m_bx[7] = 610; m_by[7] = 110; m_valid[7] = 1;
    do_frame("tp_overlap", 0, 0);

    clear_model();
    m_dx[0] = -1024; m_dy[0] = 0; m_alive[0] = 1;
    m_bx[0] = 1023; m_by[0] = 0; m_valid[0] = 1;
    m_dx[1] = 1000; m_dy[1] = 900; m_alive[1] = 1;
    m_bx[1] = 1023; m_by[1] = 931; m_valid[1] = 1;
    m_dx[3] = -1024; m_dy[3] = 990; m_alive[3] = 1;
    m_bx[4] = 0; m_by[4] = 1000; m_valid[4] = 1;
    do_frame("tp_wrap", 0, 0);

    m_dx[0] = 100; m_dy[0] = 50; m_alive[0] = 1;
    m_bx[0] = 110; m_by[0] = 60; m_valid[0] = 1;
    do_frame("tp_rep_tick", 2, 0);
    do_frame("tp_back2back", 0, 0);
    apply_reset();
    do_frame("tp_mid_tick", 1, 1);

    clear_model();
    m_dx[0] = 100; m_dy[0] = 50; m_alive[0] = 1;
    m_bx[3] = 110; m_by[3] = 60; m_valid[3] = 1;
    drive();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (19) @(negedge clk);
    reset_n = 1'b0;
    #1;
    sc_m = 0;
    ovr_m = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_hit", duck_hit, 0);
    chk("mid_rst_score", score, 0);
    chk("mid_rst_ovr", overrun, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk("mid_rst_no_pulse", {duck_hit, bullet_kill, busy}, 0);
    end

    for (int i = 0; i < 30; i++) begin
      randomize_model();
      do_frame("rand", 0, (i % 3) == 0);
    end

`ifdef DUCKHIT_SCORE_EN
    clear_model();
    for (int d = 0; d < ND; d++) begin
      m_dx[d] = 100 * d; m_dy[d] = 40; m_alive[d] = 1;
      m_bx[d] = 100 * d + 3; m_by[d] = 45; m_valid[d] = 1;
    end
    for (int i = 0; i < 66; i++) do_frame("sat", 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
